// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour constants and scroll state type
// for the 800x600@72 Hz raster-scan logo source.
package vga_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned RGB_W   = 9;
    localparam int unsigned FCNT_W  = 4;

    localparam int unsigned VGA_H_VIS   = 800;
    localparam int unsigned VGA_H_FP    = 56;
    localparam int unsigned VGA_H_SYNC  = 120;
    localparam int unsigned VGA_H_BP    = 64;
    localparam int unsigned VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int unsigned VGA_V_VIS   = 600;
    localparam int unsigned VGA_V_FP    = 37;
    localparam int unsigned VGA_V_SYNC  = 6;
    localparam int unsigned VGA_V_BP    = 23;
    localparam int unsigned VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int unsigned VGA_DELT_MAX  = 200;
    localparam int unsigned VGA_FRAME_DIV = 2;

    localparam logic [RGB_W-1:0] VGA_FG_RGB = 9'h1FF;
    localparam logic [RGB_W-1:0] VGA_BG_RGB = 9'h000;
    localparam logic [RGB_W-1:0] RGB_OFF    = 9'h000;

    typedef enum logic {
        RIGHT = 1'b0,
        LEFT  = 1'b1
    } scroll_state_e;

endpackage

// File: rtl/vga_sync_counter.sv
// Raster x/y counters with combinational sync/active decode and a
// registered frame_start pulse presented together with x=0,y=0.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS  = VGA_H_VIS,
    parameter int unsigned H_FP   = VGA_H_FP,
    parameter int unsigned H_SYNC = VGA_H_SYNC,
    parameter int unsigned H_BP   = VGA_H_BP,
    parameter int unsigned V_VIS  = VGA_V_VIS,
    parameter int unsigned V_FP   = VGA_V_FP,
    parameter int unsigned V_SYNC = VGA_V_SYNC,
    parameter int unsigned V_BP   = VGA_V_BP
) (
    input  logic               clk,
    input  logic               rst,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_frame_start,
    output logic               o_running,
    output logic               o_active_c,
    output logic               o_hsync_c,
    output logic               o_vsync_c,
    output logic               o_step_pt_c
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] X_VIS    = COORD_W'(H_VIS);
    localparam logic [COORD_W-1:0] Y_VIS    = COORD_W'(V_VIS);
    localparam logic [COORD_W-1:0] HS_BEG   = COORD_W'(H_VIS + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG   = COORD_W'(V_VIS + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VIS + V_FP + V_SYNC);
    localparam logic [COORD_W-1:0] Y_PRE_VB = COORD_W'(V_VIS - 1);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_run;
    logic               r_frame_start;

    // First clock after reset only arms the scan, so 0,0 is presented with frame_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x           <= '0;
            r_y           <= '0;
            r_run         <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (!r_run) begin
            r_run         <= 1'b1;
            r_frame_start <= 1'b1;
        end else begin
            r_frame_start <= (r_x == X_LAST) && (r_y == Y_LAST);
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_frame_start = r_frame_start;
    assign o_running     = r_run;

    assign o_active_c  = (r_x < X_VIS) && (r_y < Y_VIS);
    assign o_hsync_c   = (r_x >= HS_BEG) && (r_x < HS_END);
    assign o_vsync_c   = (r_y >= VS_BEG) && (r_y < VS_END);
    // Last cycle before x=0,y=V_VIS: an update here lands exactly on the step point.
    assign o_step_pt_c = r_run && (r_x == X_LAST) && (r_y == Y_PRE_VB);

endmodule

// File: rtl/vga_logo_scanner.sv
// Raster-scan source for the logo painters: coordinates, scroll offset, registered sync/colour.
// Scroll FSM and frame divider are built only when LOGO_SCROLL_EN is defined.
module vga_logo_scanner
    import vga_pkg::*;
#(
    parameter int unsigned      H_VIS     = VGA_H_VIS,
    parameter int unsigned      H_FP      = VGA_H_FP,
    parameter int unsigned      H_SYNC    = VGA_H_SYNC,
    parameter int unsigned      H_BP      = VGA_H_BP,
    parameter int unsigned      V_VIS     = VGA_V_VIS,
    parameter int unsigned      V_FP      = VGA_V_FP,
    parameter int unsigned      V_SYNC    = VGA_V_SYNC,
    parameter int unsigned      V_BP      = VGA_V_BP,
    parameter int unsigned      DELT_MAX  = VGA_DELT_MAX,
    parameter int unsigned      FRAME_DIV = VGA_FRAME_DIV,
    parameter logic [RGB_W-1:0] FG_RGB    = VGA_FG_RGB,
    parameter logic [RGB_W-1:0] BG_RGB    = VGA_BG_RGB
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scroll_en,
    input  logic               hit,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] delt,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic [RGB_W-1:0]   rgb
);

    logic w_running;
    logic w_active_c;
    logic w_hsync_c;
    logic w_vsync_c;
    logic w_step_pt_c;

    vga_sync_counter #(
        .H_VIS  (H_VIS),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_VIS  (V_VIS),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_sync (
        .clk           (clk),
        .rst           (rst),
        .o_x           (x),
        .o_y           (y),
        .o_frame_start (frame_start),
        .o_running     (w_running),
        .o_active_c    (w_active_c),
        .o_hsync_c     (w_hsync_c),
        .o_vsync_c     (w_vsync_c),
        .o_step_pt_c   (w_step_pt_c)
    );

    logic               r_hsync;
    logic               r_vsync;
    logic [RGB_W-1:0]   r_rgb;

    // Sync and colour share one pipeline stage so they stay aligned at the pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync <= 1'b0;
            r_vsync <= 1'b0;
            r_rgb   <= RGB_OFF;
        end else if (w_running) begin
            r_hsync <= w_hsync_c;
            r_vsync <= w_vsync_c;
            r_rgb   <= !w_active_c ? RGB_OFF : (hit ? FG_RGB : BG_RGB);
        end
    end

    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign rgb   = r_rgb;

`ifdef LOGO_SCROLL_EN
    localparam logic [FCNT_W-1:0]  DIV_LAST = FCNT_W'(FRAME_DIV - 1);
    localparam logic [COORD_W-1:0] DELT_TOP = COORD_W'(DELT_MAX);

    scroll_state_e      r_state;
    scroll_state_e      w_state_nxt;
    logic [COORD_W-1:0] r_delt;
    logic [COORD_W-1:0] w_delt_nxt;
    logic [FCNT_W-1:0]  r_fcnt;
    logic [FCNT_W-1:0]  w_fcnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RIGHT;
            r_delt  <= '0;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_delt  <= w_delt_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // Frame divider always runs; the offset only moves when scrolling is enabled.
    always_comb begin
        w_state_nxt = r_state;
        w_delt_nxt  = r_delt;
        w_fcnt_nxt  = r_fcnt;
        if (w_step_pt_c) begin
            if (r_fcnt == DIV_LAST) begin
                w_fcnt_nxt = '0;
                if (scroll_en) begin
                    unique case (r_state)
                        RIGHT: begin
                            w_delt_nxt = r_delt + 1'b1;
                            if (w_delt_nxt == DELT_TOP) w_state_nxt = LEFT;
                        end
                        LEFT: begin
                            w_delt_nxt = r_delt - 1'b1;
                            if (w_delt_nxt == '0) w_state_nxt = RIGHT;
                        end
                    endcase
                end
            end else begin
                w_fcnt_nxt = r_fcnt + 1'b1;
            end
        end
    end

    assign delt = r_delt;
`else
    localparam int unsigned unused_cfg = DELT_MAX + FRAME_DIV;
    logic w_unused;

    assign w_unused = ^{scroll_en, w_step_pt_c};
    assign delt     = '0;
`endif

endmodule

// File: tb/tb_vga_logo_scanner.sv
// Self-checking bench for vga_logo_scanner on a shrunken raster with randomized hit.
module tb_vga_logo_scanner;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 6, VF = 2, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int DMAX = 3;
    localparam int FDIV = 2;
    localparam logic [8:0] FG = 9'h1C7;
    localparam logic [8:0] BG = 9'h038;
`ifdef LOGO_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        scroll_en;
    logic        hit;
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] delt;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic [8:0]  rgb;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int k;
    int mx, my;
    bit m_valid;
    int m_delt, m_dir, m_sp;
    int n_fs;

    vga_logo_scanner #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .DELT_MAX(DMAX), .FRAME_DIV(FDIV),
        .FG_RGB(FG), .BG_RGB(BG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scroll_en   (scroll_en),
        .hit         (hit),
        .x           (x),
        .y           (y),
        .delt        (delt),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        k       = 0;
        mx      = 0;
        my      = 0;
        m_valid = 1'b0;
        m_delt  = 0;
        m_dir   = 1;
        m_sp    = 0;
        n_fs    = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_x"},     16'(x),           16'(0));
        chk({tag, "_y"},     16'(y),           16'(0));
        chk({tag, "_delt"},  16'(delt),        16'(0));
        chk({tag, "_fs"},    16'(frame_start), 16'(0));
        chk({tag, "_hsync"}, 16'(hsync),       16'(0));
        chk({tag, "_vsync"}, 16'(vsync),       16'(0));
        chk({tag, "_rgb"},   16'(rgb),         16'(0));
    endtask

    // One clock: predict every output from raster position and scroll history, then compare.
    task automatic tick();
        int p, nx, ny;
        logic       e_hs, e_vs, e_fs;
        logic [8:0] e_rgb;
        @(posedge clk);
        #1;
        if (m_valid) begin
            e_hs  = (mx >= HV + HF) && (mx < HV + HF + HS);
            e_vs  = (my >= VV + VF) && (my < VV + VF + VS);
            e_rgb = (mx < HV && my < VV) ? (hit ? FG : BG) : 9'h000;
        end else begin
            e_hs  = 1'b0;
            e_vs  = 1'b0;
            e_rgb = 9'h000;
        end
        k++;
        p    = (k - 1) % FT;
        nx   = p % HT;
        ny   = p / HT;
        e_fs = (p == 0);
        if (SCROLL && p == VV * HT) begin
            m_sp++;
            if (scroll_en && (m_sp % FDIV == 0)) begin
                m_delt += m_dir;
                if (m_delt == DMAX || m_delt == 0) m_dir = -m_dir;
            end
        end
        mx      = nx;
        my      = ny;
        m_valid = 1'b1;
        if (frame_start === 1'b1) n_fs++;
        chk("x",     16'(x),           16'(mx));
        chk("y",     16'(y),           16'(my));
        chk("fs",    16'(frame_start), 16'(e_fs));
        chk("hsync", 16'(hsync),       16'(e_hs));
        chk("vsync", 16'(vsync),       16'(e_vs));
        chk("rgb",   16'(rgb),         16'(e_rgb));
        chk("delt",  16'(delt),        16'(m_delt));
        hit = 1'($urandom_range(0, 1));
    endtask

    initial begin
        rst       = 1'b1;
        scroll_en = 1'b1;
        hit       = 1'b0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");

        // release; nothing moves until the first clock
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("prerun_x",  16'(x),           16'(0));
        chk("prerun_y",  16'(y),           16'(0));
        chk("prerun_fs", 16'(frame_start), 16'(0));

        // two frames: one frame_start per frame, first on first clock
        repeat (2 * FT) tick();
        chk("fs_count_2frames", 16'(n_fs), 16'(2));

        // scroll bounce through 0..DMAX and back
        repeat (14 * FT) tick();

        // freeze at delt=2
        for (int i = 0; i < 4 * FT * FDIV && m_delt != 2; i++) tick();
        scroll_en = 1'b0;
        repeat (5 * FT) tick();
        chk("delt_frozen", 16'(delt), 16'(m_delt));

        // resume in same direction
        scroll_en = 1'b1;
        repeat (6 * FT) tick();

        // asynchronous reset mid-frame in the visible area
        for (int i = 0; i < 2 * FT && !(my == VV / 2 && mx == 2); i++) tick();
        chk("prereset_rgb_active", 16'(rgb != 9'h000), 16'(1));
        rst = 1'b1;
        #2;
        check_all_zero("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2 * FT) tick();
        chk("fs_count_after_rst", 16'(n_fs), 16'(2));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
